// File: rtl/bt656_stream_decoder.sv
// BT.656 drain-side decoder: finds EAV/SAV timing codes, repacks active 4:2:2 words
// into {chroma,luma} beats with SOF/EOL markers, and tracks line/field statistics.
module bt656_stream_decoder #(
  parameter int DW         = 10,
  parameter bit CHECK_PROT = 1'b1,
  parameter int LCW        = 12
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [DW-1:0]   bt_data_i,
  output logic [2*DW-1:0] m_tdata_o,
  output logic            m_tvalid_o,
  input  logic            m_tready_i,
  output logic            m_tuser_o,
  output logic            m_tlast_o,
  output logic            field_o,
  output logic [LCW-1:0]  line_len_o,
  output logic [LCW-1:0]  field_lines_o,
  input  logic            clr_i,
  output logic            hdr_err_o,
  output logic            odd_err_o,
  output logic            ovf_err_o
);

  typedef enum logic [2:0] {S_SEARCH, S_P1, S_P2, S_XY, S_ACTIVE} state_t;

  localparam logic [LCW-1:0] CNT_MAX = '1;

  state_t          r_state, w_state_next;
  logic [DW-1:0]   r_d1;
  logic [7:0]      w_code;
  logic            w_is_ff, w_is_00, w_f, w_v, w_h, w_hdr_ok;
  logic            w_hdr_bad, w_hdr_good, w_eol, w_word;

  logic [DW-1:0]   r_chroma;
  logic            r_phase;
  logic [2*DW-1:0] r_hold;
  logic            r_hold_valid, r_hold_user, r_sof_pend;
  logic [LCW-1:0]  r_pair_cnt, r_line_cnt, r_line_len, r_field_lines;
  logic [2*DW-1:0] r_tdata;
  logic            r_tvalid, r_tuser, r_tlast, r_field;
  logic            r_hdr_err, r_odd_err, r_ovf_err;

  assign w_code   = r_d1[DW-1:DW-8];
  assign w_is_ff  = (w_code == 8'hFF);
  assign w_is_00  = (w_code == 8'h00);
  assign w_f      = w_code[6];
  assign w_v      = w_code[5];
  assign w_h      = w_code[4];
  assign w_hdr_ok = w_code[7] &&
                    (!CHECK_PROT || (w_code[3:0] == {w_v ^ w_h, w_f ^ w_h, w_f ^ w_v, w_f ^ w_v ^ w_h}));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) r_state <= S_SEARCH;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_hdr_bad    = 1'b0;
    w_hdr_good   = 1'b0;
    w_eol        = 1'b0;
    w_word       = 1'b0;
    case (r_state)
      S_SEARCH: if (w_is_ff) w_state_next = S_P1;
      S_P1:     w_state_next = w_is_00 ? S_P2 : S_SEARCH;
      S_P2:     w_state_next = w_is_00 ? S_XY : S_SEARCH;
      S_XY: begin
        if (!w_hdr_ok) begin
          w_hdr_bad    = 1'b1;
          w_state_next = S_SEARCH;
        end else begin
          w_hdr_good   = 1'b1;
          w_state_next = (!w_h && !w_v) ? S_ACTIVE : S_SEARCH;
        end
      end
      S_ACTIVE: begin
        if (w_is_ff) begin
          w_eol        = 1'b1;
          w_state_next = S_P1;
        end else begin
          w_word = 1'b1;
        end
      end
      default: w_state_next = S_SEARCH;
    endcase
  end

  // One pair is always held back so the last pair of a line can carry tlast at the FF.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_d1          <= '0;
      r_chroma      <= '0;
      r_phase       <= 1'b0;
      r_hold        <= '0;
      r_hold_valid  <= 1'b0;
      r_hold_user   <= 1'b0;
      r_sof_pend    <= 1'b0;
      r_pair_cnt    <= '0;
      r_line_cnt    <= '0;
      r_line_len    <= '0;
      r_field_lines <= '0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_tuser       <= 1'b0;
      r_tlast       <= 1'b0;
      r_field       <= 1'b0;
      r_hdr_err     <= 1'b0;
      r_odd_err     <= 1'b0;
      r_ovf_err     <= 1'b0;
    end else begin
      r_d1     <= bt_data_i;
      r_tvalid <= 1'b0;
      r_tuser  <= 1'b0;
      r_tlast  <= 1'b0;

      if (w_hdr_good) begin
        r_field <= w_f;
        if (w_v) begin
          r_sof_pend <= 1'b1;
          if (r_line_cnt != '0) begin
            r_field_lines <= r_line_cnt;
            r_line_cnt    <= '0;
          end
        end
        if (!w_h && !w_v) begin
          r_pair_cnt   <= '0;
          r_phase      <= 1'b0;
          r_hold_valid <= 1'b0;
        end
      end

      if (w_word) begin
        if (!r_phase) begin
          r_chroma <= r_d1;
          r_phase  <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          if (r_hold_valid) begin
            r_tdata  <= r_hold;
            r_tvalid <= 1'b1;
            r_tuser  <= r_hold_user;
          end
          r_hold       <= {r_chroma, r_d1};
          r_hold_valid <= 1'b1;
          r_hold_user  <= r_sof_pend;
          r_sof_pend   <= 1'b0;
          r_pair_cnt   <= (r_pair_cnt == CNT_MAX) ? r_pair_cnt : r_pair_cnt + 1'b1;
        end
      end

      if (w_eol) begin
        if (r_hold_valid) begin
          r_tdata  <= r_hold;
          r_tvalid <= 1'b1;
          r_tuser  <= r_hold_user;
          r_tlast  <= 1'b1;
        end
        r_hold_valid <= 1'b0;
        r_phase      <= 1'b0;
        r_line_len   <= r_pair_cnt;
        if (r_pair_cnt != '0 && r_line_cnt != CNT_MAX) r_line_cnt <= r_line_cnt + 1'b1;
      end

      r_hdr_err <= w_hdr_bad | (r_hdr_err & ~clr_i);
      r_odd_err <= (w_eol & r_phase) | (r_odd_err & ~clr_i);
      r_ovf_err <= (r_tvalid & ~m_tready_i) | (r_ovf_err & ~clr_i);
    end
  end

  assign m_tdata_o     = r_tdata;
  assign m_tvalid_o    = r_tvalid;
  assign m_tuser_o     = r_tuser;
  assign m_tlast_o     = r_tlast;
  assign field_o       = r_field;
  assign line_len_o    = r_line_len;
  assign field_lines_o = r_field_lines;
  assign hdr_err_o     = r_hdr_err;
  assign odd_err_o     = r_odd_err;
  assign ovf_err_o     = r_ovf_err;

endmodule
